// File: rtl/dm_bridge.sv
// Data-memory bridge: turns the CPU's combinational load/store into a registered
// request/ready transaction, stalling the CPU until the target responds or times out.
module dm_bridge #(
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_wea,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        bus_err,
    output logic [31:0] err_addr,
    output logic [31:0] acc_cnt
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] wait_cnt;
    logic [31:0] req_addr;

    // DONE is the single commit cycle; every other cycle of a request holds the CPU.
    assign cpu_stall = cpu_req & (state != DONE);

    // req_addr keeps the unaligned CPU address so err_addr reports what the program issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            req_addr  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            bus_err   <= 1'b0;
            err_addr  <= '0;
            acc_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= cpu_we;
                        mem_be    <= cpu_we ? cpu_wea : 4'hF;
                        mem_addr  <= {cpu_addr[31:2], 2'b00};
                        mem_wdata <= cpu_wdata;
                        req_addr  <= cpu_addr;
                        wait_cnt  <= '0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    wait_cnt <= wait_cnt + 16'd1;
                    // A ready arriving on the final allowed cycle still wins over the timeout.
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            cpu_rdata <= mem_rdata;
                        end
                        state <= DONE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        mem_req   <= 1'b0;
                        cpu_rdata <= ERR_RDATA;
                        bus_err   <= 1'b1;
                        if (!bus_err) begin
                            err_addr <= req_addr;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    acc_cnt <= acc_cnt + 32'd1;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
